// File: rtl/sev_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: digit count,
// FSM state encoding and the registered pin bundle with its idle patterns.
package sev_seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Inactive pin patterns for each polarity
  localparam logic [SEG_W-1:0]      SEG_OFF_AL = 7'h7F;
  localparam logic [SEG_W-1:0]      SEG_OFF_AH = 7'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF_AL = 4'hF;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF_AH = 4'h0;

  // Pin bundle held in the output register, in logical (1 = lit) sense
  // until converted by pins_apply.
  typedef struct packed {
    logic [SEG_W-1:0]      seg;
    logic                  dot;
    logic [NUM_DIGITS-1:0] sel;
  } pins_t;

  // All pins inactive for the given polarity
  function automatic pins_t pins_off(input bit active_low);
    pins_t p;
    p.seg = active_low ? SEG_OFF_AL : SEG_OFF_AH;
    p.dot = active_low;
    p.sel = active_low ? SEL_OFF_AL : SEL_OFF_AH;
    return p;
  endfunction

  // Convert a logical pin bundle to board polarity
  function automatic pins_t pins_apply(input bit active_low, input pins_t raw);
    pins_t p;
    p = active_low ? pins_t'(~raw) : raw;
    return p;
  endfunction

endpackage

// File: rtl/sev_seg_slot_timer.sv
// Digit slot timer. Owns the slot counter cnt (0 .. CLK_DIV-1).
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : hold the counter at zero (display disabled / not yet started)
//   slot_end  : cnt is at the last cycle of the slot
//   in_blank  : the count after the coming edge lies inside the blank window,
//               so the registered pins can be decided on the same edge
module sev_seg_slot_timer #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic slot_end,
  output logic in_blank
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count and lookahead blank flag
  always_comb begin
    slot_end = (cnt == CNT_W'(CLK_DIV - 1));
    cnt_nxt  = cnt + CNT_W'(1);
    if (clr || slot_end) begin
      cnt_nxt = '0;
    end
    in_blank = (cnt_nxt < CNT_W'(BLANK_CYCLES));
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/sev_seg_scan_controller.sv
// Four-digit seven-segment scan controller. Drives one digit per slot with a
// leading blank gap; segment data is latched at each slot boundary.
//   clk, rst          : clock, asynchronous active-high reset
//   ctrl_en           : display enable
//   ctrl_digit_0..3   : segment patterns (bit 0 = a), 1 = lit
//   ctrl_dots         : decimal point per digit, 1 = lit
//   seg_out, dot_out  : segment / decimal-point pins (polarity per ACTIVE_LOW)
//   digit_sel         : one-hot digit enables (polarity per ACTIVE_LOW)
//   frame_done        : one-cycle pulse after the digit 3 slot ends
module sev_seg_scan_controller
  import sev_seg_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_en,
  input  logic [6:0] ctrl_digit_0,
  input  logic [6:0] ctrl_digit_1,
  input  logic [6:0] ctrl_digit_2,
  input  logic [6:0] ctrl_digit_3,
  input  logic [3:0] ctrl_dots,
  output logic [6:0] seg_out,
  output logic       dot_out,
  output logic [3:0] digit_sel,
  output logic       frame_done
);

  localparam pins_t PINS_OFF = pins_off(ACTIVE_LOW);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [SEG_W-1:0] lat_seg, lat_seg_nxt;
  logic             lat_dot, lat_dot_nxt;
  pins_t            pins_q, pins_nxt;
  logic             frame_done_nxt;
  logic             slot_end;
  logic             in_blank;
  logic             timer_clr;

  // The counter restarts from zero on the enabling edge
  assign timer_clr = !ctrl_en || (state == IDLE);

  sev_seg_slot_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .slot_end (slot_end),
    .in_blank (in_blank)
  );

  // State, digit index, latches and next pin values
  always_comb begin
    logic load;
    pins_t raw;

    state_nxt      = state;
    idx_nxt        = idx;
    lat_seg_nxt    = lat_seg;
    lat_dot_nxt    = lat_dot;
    frame_done_nxt = 1'b0;
    pins_nxt       = PINS_OFF;
    load           = 1'b0;
    raw            = '0;

    if (!ctrl_en) begin
      // Disable wins over everything, including a slot end
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      state_nxt = in_blank ? BLANK : DRIVE;
      if (state == IDLE) begin
        idx_nxt = '0;
        load    = 1'b1;
      end else if (slot_end) begin
        idx_nxt        = idx + IDX_W'(1);
        load           = 1'b1;
        frame_done_nxt = (idx == IDX_W'(NUM_DIGITS - 1));
      end
    end

    // Latch the new digit's data only at a slot boundary
    if (load) begin
      case (idx_nxt)
        2'd0:    lat_seg_nxt = ctrl_digit_0;
        2'd1:    lat_seg_nxt = ctrl_digit_1;
        2'd2:    lat_seg_nxt = ctrl_digit_2;
        default: lat_seg_nxt = ctrl_digit_3;
      endcase
      lat_dot_nxt = ctrl_dots[idx_nxt];
    end

    if (state_nxt == DRIVE) begin
      raw.seg  = lat_seg_nxt;
      raw.dot  = lat_dot_nxt;
      raw.sel  = NUM_DIGITS'(1) << idx_nxt;
      pins_nxt = pins_apply(ACTIVE_LOW, raw);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      lat_seg    <= '0;
      lat_dot    <= 1'b0;
      pins_q     <= PINS_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      lat_seg    <= lat_seg_nxt;
      lat_dot    <= lat_dot_nxt;
      pins_q     <= pins_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  assign seg_out   = pins_q.seg;
  assign dot_out   = pins_q.dot;
  assign digit_sel = pins_q.sel;

endmodule

// File: tb/tb_sev_seg_scan_controller.sv
// Bench for sev_seg_scan_controller. Two instances share the stimulus:
// A (CLK_DIV 8, BLANK 2, active-low) and B (CLK_DIV 4, BLANK 0, active-high).
module tb_sev_seg_scan_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [6:0] dig [4];
  logic [3:0] dots;

  logic [6:0] seg_a, seg_b;
  logic       dot_a, dot_b;
  logic [3:0] sel_a, sel_b;
  logic       fd_a, fd_b;

  always #5 clk = ~clk;

  sev_seg_scan_controller #(.CLK_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .rst(rst), .ctrl_en(en),
    .ctrl_digit_0(dig[0]), .ctrl_digit_1(dig[1]), .ctrl_digit_2(dig[2]), .ctrl_digit_3(dig[3]),
    .ctrl_dots(dots), .seg_out(seg_a), .dot_out(dot_a), .digit_sel(sel_a), .frame_done(fd_a)
  );

  sev_seg_scan_controller #(.CLK_DIV(4), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b0)) u_b (
    .clk(clk), .rst(rst), .ctrl_en(en),
    .ctrl_digit_0(dig[0]), .ctrl_digit_1(dig[1]), .ctrl_digit_2(dig[2]), .ctrl_digit_3(dig[3]),
    .ctrl_dots(dots), .seg_out(seg_b), .dot_out(dot_b), .digit_sel(sel_b), .frame_done(fd_b)
  );

  // Reference model state per instance (0 = A, 1 = B)
  int         m_div [2] = '{8, 4};
  int         m_blk [2] = '{2, 0};
  bit         m_al  [2] = '{1'b1, 1'b0};
  bit         m_on  [2];
  int         m_t   [2];
  int         m_d   [2];
  logic [6:0] m_seg [2];
  logic       m_dot [2];
  logic       m_fd  [2];

  typedef struct packed {
    logic [12:0] a;
    logic [12:0] b;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   fd_cnt;

  logic [6:0] seg_lit [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
  logic       dot_lit [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_on[k] = 1'b0; m_t[k] = 0; m_d[k] = 0;
      m_seg[k] = '0; m_dot[k] = 1'b0; m_fd[k] = 1'b0;
    end
  endfunction

  // Advance one instance's model across a clock edge using current inputs
  function automatic void model_edge(int k);
    if (rst) begin
      m_on[k] = 1'b0; m_t[k] = 0; m_d[k] = 0;
      m_seg[k] = '0; m_dot[k] = 1'b0; m_fd[k] = 1'b0;
    end else if (!en) begin
      m_on[k] = 1'b0; m_t[k] = 0; m_d[k] = 0; m_fd[k] = 1'b0;
    end else if (!m_on[k]) begin
      m_on[k] = 1'b1; m_t[k] = 0; m_d[k] = 0; m_fd[k] = 1'b0;
      m_seg[k] = dig[0]; m_dot[k] = dots[0];
    end else if (m_t[k] == m_div[k] - 1) begin
      m_t[k]  = 0;
      m_fd[k] = (m_d[k] == 3);
      m_d[k]  = (m_d[k] + 1) % 4;
      m_seg[k] = dig[m_d[k]]; m_dot[k] = dots[m_d[k]];
    end else begin
      m_t[k]  = m_t[k] + 1;
      m_fd[k] = 1'b0;
    end
  endfunction

  // Expected {seg, dot, sel, frame_done} for one instance
  function automatic logic [12:0] model_out(int k);
    logic       drive;
    logic [6:0] s;
    logic       d;
    logic [3:0] sl;
    drive = m_on[k] && (m_t[k] >= m_blk[k]);
    s  = drive ? m_seg[k] : 7'h00;
    d  = drive ? m_dot[k] : 1'b0;
    sl = 4'h0;
    if (drive) sl[m_d[k]] = 1'b1;
    if (m_al[k]) begin
      s = ~s; d = ~d; sl = ~sl;
    end
    return {s, d, sl, m_fd[k]};
  endfunction

  // Drive one clock: push the expected outputs, then let the edge happen
  task automatic step();
    exp_t e;
    model_edge(0);
    model_edge(1);
    e.a = model_out(0);
    e.b = model_out(1);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (fd_a) fd_cnt++;
    cyc++;
  endtask

  // Scoreboard: pop and compare once outputs have settled
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      n_vec++;
      if ({seg_a, dot_a, sel_a, fd_a} !== mon_e.a) begin
        n_err++;
        $display("FAIL sb_a cyc=%0d got=%h exp=%h", cyc, {seg_a, dot_a, sel_a, fd_a}, mon_e.a);
      end
      n_vec++;
      if ({seg_b, dot_b, sel_b, fd_b} !== mon_e.b) begin
        n_err++;
        $display("FAIL sb_b cyc=%0d got=%h exp=%h", cyc, {seg_b, dot_b, sel_b, fd_b}, mon_e.b);
      end
      n_vec++;
      if ($countones(~sel_a) > 1 || $countones(sel_b) > 1) begin
        n_err++;
        $display("FAIL onehot cyc=%0d got a=%b b=%b exp at most one active", cyc, sel_a, sel_b);
      end
    end
  end

  task automatic restart();
    en = 1'b0;
    step();
    en = 1'b1;
    fd_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; dots = 4'b0101;
    dig[0] = 7'h06; dig[1] = 7'h5B; dig[2] = 7'h4F; dig[3] = 7'h66;
    #1 rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({seg_a, dot_a, sel_a, fd_a} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      n_err++;
      $display("FAIL reset_a got=%h exp=%h", {seg_a, dot_a, sel_a, fd_a}, {7'h7F, 1'b1, 4'hF, 1'b0});
    end
    n_vec++;
    if ({seg_b, dot_b, sel_b, fd_b} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_b got=%h exp=0", {seg_b, dot_b, sel_b, fd_b});
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_scan();
    int first_fd;
    logic [3:0] want;
    first_fd = 0;
    restart();
    for (int n = 1; n <= 65; n++) begin
      int t, dg;
      step();
      t  = (n - 1) % 8;
      dg = ((n - 1) / 8) % 4;
      if (fd_a && first_fd == 0) first_fd = n;
      want = (t >= 2) ? ~(4'b0001 << dg) : 4'hF;
      n_vec++;
      if (sel_a !== want || (t >= 2 && (seg_a !== seg_lit[dg] || dot_a !== dot_lit[dg]))) begin
        n_err++;
        $display("FAIL basic_scan n=%0d got sel=%b seg=%h dot=%b exp sel=%b seg=%h dot=%b",
                 n, sel_a, seg_a, dot_a, want, seg_lit[dg], dot_lit[dg]);
      end
    end
    n_vec++;
    if (fd_cnt !== 2 || first_fd !== 33) begin
      n_err++;
      $display("FAIL frame_done_period got count=%0d first=%0d exp count=2 first=33", fd_cnt, first_fd);
    end
  endtask

  task automatic test_latching();
    restart();
    for (int n = 1; n <= 48; n++) begin
      step();
      if (n == 12) dig[1] = 7'h3F;
      if (n >= 12 && n <= 16) begin
        n_vec++;
        if (seg_a !== 7'h24 || sel_a !== 4'b1101) begin
          n_err++;
          $display("FAIL latch_hold n=%0d got seg=%h sel=%b exp seg=24 sel=1101", n, seg_a, sel_a);
        end
      end
      if (n >= 43) begin
        n_vec++;
        if (seg_a !== 7'h40 || sel_a !== 4'b1101) begin
          n_err++;
          $display("FAIL latch_new n=%0d got seg=%h sel=%b exp seg=40 sel=1101", n, seg_a, sel_a);
        end
      end
    end
    dig[1] = 7'h5B;
  endtask

  task automatic test_enable_toggle();
    restart();
    for (int n = 1; n <= 20; n++) step();
    n_vec++;
    if (sel_a !== 4'b1011) begin
      n_err++;
      $display("FAIL toggle_pre got sel=%b exp 1011", sel_a);
    end
    en = 1'b0;
    step();
    n_vec++;
    if ({seg_a, dot_a, sel_a, fd_a} !== {7'h7F, 1'b1, 4'hF, 1'b0} || {seg_b, dot_b, sel_b} !== 12'h0) begin
      n_err++;
      $display("FAIL toggle_off got a=%h b=%h exp a=%h b=0", {seg_a, dot_a, sel_a, fd_a},
               {seg_b, dot_b, sel_b}, {7'h7F, 1'b1, 4'hF, 1'b0});
    end
    step();
    en = 1'b1;
    fd_cnt = 0;
    for (int n = 1; n <= 33; n++) begin
      step();
      if (n <= 2) begin
        n_vec++;
        if (sel_a !== 4'hF) begin
          n_err++;
          $display("FAIL toggle_blank n=%0d got sel=%b exp 1111", n, sel_a);
        end
      end
      if (n == 3) begin
        n_vec++;
        if (sel_a !== 4'b1110 || seg_a !== 7'h79) begin
          n_err++;
          $display("FAIL toggle_restart got sel=%b seg=%h exp sel=1110 seg=79", sel_a, seg_a);
        end
      end
      if (n == 32) begin
        n_vec++;
        if (fd_cnt !== 0) begin
          n_err++;
          $display("FAIL toggle_no_fd got count=%0d exp 0", fd_cnt);
        end
      end
    end
    n_vec++;
    if (fd_cnt !== 1) begin
      n_err++;
      $display("FAIL toggle_fd got count=%0d exp 1", fd_cnt);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    for (int n = 1; n <= 27; n++) step();
    n_vec++;
    if (sel_a !== 4'b0111 || seg_a !== 7'h19) begin
      n_err++;
      $display("FAIL rstmid_pre got sel=%b seg=%h exp sel=0111 seg=19", sel_a, seg_a);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({seg_a, dot_a, sel_a, fd_a} !== {7'h7F, 1'b1, 4'hF, 1'b0} || {seg_b, dot_b, sel_b, fd_b} !== 13'h0) begin
      n_err++;
      $display("FAIL rstmid_async got a=%h b=%h exp a=%h b=0", {seg_a, dot_a, sel_a, fd_a},
               {seg_b, dot_b, sel_b, fd_b}, {7'h7F, 1'b1, 4'hF, 1'b0});
    end
    step();
    step();
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 3) begin
        n_vec++;
        if (sel_a !== 4'b1110 || seg_a !== 7'h79) begin
          n_err++;
          $display("FAIL rstmid_resume got sel=%b seg=%h exp sel=1110 seg=79", sel_a, seg_a);
        end
      end
    end
  endtask

  task automatic test_polarity();
    restart();
    for (int n = 1; n <= 20; n++) begin
      int dg;
      logic [3:0] want;
      step();
      dg   = ((n - 1) / 4) % 4;
      want = 4'b0001 << dg;
      n_vec++;
      if (sel_b !== want || seg_b !== dig[dg] || dot_b !== dots[dg]) begin
        n_err++;
        $display("FAIL polarity n=%0d got sel=%b seg=%h dot=%b exp sel=%b seg=%h dot=%b",
                 n, sel_b, seg_b, dot_b, want, dig[dg], dots[dg]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_scan();
    test_latching();
    test_enable_toggle();
    test_reset_mid();
    test_polarity();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan_controller.md
# sev_seg_scan_controller

Time-multiplexing scan controller for the four-digit seven-segment display. It sits between the seven-segment bus interface register outputs and the board pins, and turns the static digit/dot registers into a one-digit-at-a-time drive pattern. Each digit slot has a programmable blanking gap that suppresses ghosting. Segment data is latched per slot, so a bus write never tears a digit mid-slot.

## Interface

Parameters:
- CLK_DIV, 50000: clk cycles per digit slot; must be at least 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all outputs inactive; must be less than CLK_DIV.
- ACTIVE_LOW, 1: polarity of seg_out, dot_out and digit_sel.
  - 1: an active segment or digit is driven 0.
  - 0: an active segment or digit is driven 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- ctrl_en  in  1  display enable, from the bus interface.
- ctrl_digit_0 … ctrl_digit_3  in  7 each  segment patterns; bit 0 = segment a, bit 1 = segment b, and so on; 1 = lit.
- ctrl_dots  in  4  decimal point per digit; 1 = lit.
- seg_out  out  7  segment pins.
- dot_out  out  1  decimal-point pin.
- digit_sel  out  4  one-hot digit enable pins; bit i selects digit i.
- frame_done  out  1  one-cycle pulse when the digit 3 slot ends.

## Operation

- States:
  - IDLE: ctrl_en low.
  - BLANK: slot counter cnt < BLANK_CYCLES.
  - DRIVE: cnt ≥ BLANK_CYCLES.
- Registers:
  - cnt: 0 … CLK_DIV−1.
  - idx: 2 bits.
  - lat_seg: 7 bits.
  - lat_dot: 1 bit.
- Transitions from IDLE:
  - IDLE → BLANK on an edge where ctrl_en = 1.
  - On that edge: cnt ← 0, idx ← 0, lat_seg ← ctrl_digit_0, lat_dot ← ctrl_dots[0].
- Transitions within a slot:
  - BLANK → DRIVE when cnt reaches BLANK_CYCLES.
  - If BLANK_CYCLES = 0, the slot starts directly in DRIVE.
- Slot end (cnt = CLK_DIV−1), next edge:
  - cnt ← 0 and idx ← idx+1, wrapping 3 → 0.
  - lat_seg ← ctrl_digit_[new idx], lat_dot ← ctrl_dots[new idx].
  - State returns to BLANK.
- Any state → IDLE on an edge where ctrl_en = 0. This takes priority over everything else, including a slot end.
- On entry to IDLE: cnt ← 0, idx ← 0, frame_done ← 0.
- Outputs in IDLE and BLANK, all inactive:
  - seg_out = 7'h7F and dot_out = 1 when ACTIVE_LOW = 1.
  - digit_sel = 4'hF when ACTIVE_LOW = 1.
  - All zeros when ACTIVE_LOW = 0.
- Outputs in DRIVE:
  - digit_sel has only bit idx active.
  - seg_out = lat_seg and dot_out = lat_dot, each inverted when ACTIVE_LOW = 1.
- Input changes during a slot are ignored until the next slot boundary.
- Reset values:
  - seg_out, dot_out and digit_sel inactive per ACTIVE_LOW.
  - frame_done = 0.
  - State IDLE; cnt, idx, lat_seg and lat_dot all 0.

## Timing

- All outputs are registers, updated on the same edge as state, cnt and idx. There is no extra pipeline stage and no combinational path from inputs to pins.
- Slot length is exactly CLK_DIV cycles. Each slot has BLANK_CYCLES blank cycles followed by CLK_DIV−BLANK_CYCLES driven cycles.
- Frame length is 4·CLK_DIV cycles.
- frame_done is high for the single cycle immediately after the edge that wraps idx from 3 to 0.
- Enable timing:
  - ctrl_en rising: the first blank cycle begins after the next edge; digit 0 drives BLANK_CYCLES cycles later.
  - ctrl_en falling: pins are inactive after the next edge; a partial slot is simply abandoned.
- Asynchronous rst forces the reset values immediately, even mid-slot. Operation restarts at digit 0 once rst is released and ctrl_en is high.
- At no edge may two digit_sel bits be active at the same time.

## Structure

- Shared package sev_seg_pkg:
  - NUM_DIGITS = 4.
  - State encoding: IDLE, BLANK, DRIVE.
  - Inactive pattern constants for both polarities.
- Sub-module sev_seg_slot_timer:
  - Owns cnt.
  - Outputs slot_end and in_blank.
  - Clear input, asserted while ctrl_en is low.
- The top level holds the FSM, idx, the latches and the output registers.

## Test plan

- **Reset:** assert rst with ACTIVE_LOW = 1 → seg_out = 7'h7F, dot_out = 1, digit_sel = 4'hF, frame_done = 0.
- **Basic scan:** CLK_DIV = 8, BLANK_CYCLES = 2, digits 7'h06/7'h5B/7'h4F/7'h66, dots 4'b0101, ctrl_en = 1.
  - digit_sel runs 1110, 1101, 1011, 0111, each active for 6 cycles after 2 blank cycles.
  - seg_out = 7'h79 / 7'h24 / 7'h30 / 7'h19.
  - dot_out = 0 only on digits 0 and 2.
  - frame_done pulses every 32 cycles.
- **Latching:** change ctrl_digit_1 to 7'h3F during the digit 1 DRIVE phase → seg_out holds 7'h24 until the slot ends; the next digit 1 slot shows 7'h40.
- **Enable toggle:** drop ctrl_en mid-DRIVE on digit 2 → all outputs inactive after one edge. Raise it again → the scan restarts at digit 0 with 2 blank cycles; no frame_done pulse for the aborted frame.
- **Reset mid-operation:** pulse rst during digit 3 DRIVE → outputs go inactive immediately; after release the scan resumes at digit 0.
- **Polarity and degenerate blanking:** ACTIVE_LOW = 0, BLANK_CYCLES = 0 → digit_sel goes 0001, 0010, 0100, 1000 with no blank cycles; seg_out = raw digit values; checker confirms at most one digit_sel bit is active on every cycle.
